mm2x2_sequencer: RTL and testbench

Sequencer and scheduler for a 2x2 matrix-multiply datapath in the TinyTapeout project, placed between the pin-level I/O and the arithmetic.
- Accepts eight operand elements over a valid/ready byte stream and stores them.
- Time-shares one multiply-accumulate unit over the eight partial products.
- Streams the four result elements out over a second valid/ready channel.

---
 rtl/mm2x2_sequencer_pkg.sv | 19 +
 rtl/mm2x2_sequencer_if.sv | 29 ++
 rtl/mm2x2_sequencer_mac.sv | 48 ++++
 rtl/mm2x2_sequencer.sv | 141 ++++++++++++++
 tb/tb_mm2x2_sequencer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm2x2_sequencer_pkg.sv
// Shared types and constants for the 2x2 matrix-multiply sequencer.
package mm2x2_seq_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam int N_OPERANDS = 8;
    localparam int N_PRODUCTS = 8;
    localparam int N_RESULTS  = 4;

    // Two products of 2*DATA_W bits summed need one extra bit.
    function automatic int res_w(input int data_w);
        return 2 * data_w + 1;
    endfunction

endpackage

// File: rtl/mm2x2_sequencer_if.sv
// Operand and result valid/ready channels of the 2x2 matrix-multiply sequencer.
interface mm2x2_sequencer_if #(
    parameter int DATA_W = 4
) ();
    import mm2x2_seq_pkg::*;

    localparam int RES_W = res_w(DATA_W);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [RES_W-1:0]  out_data;
    logic [1:0]        out_idx;
    logic              out_valid;
    logic              out_ready;

    // Sequencer side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_idx, out_valid
    );

    // Producer / consumer side.
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_idx, out_valid
    );

endinterface

// File: rtl/mm2x2_sequencer_mac.sv
// Shared multiply-accumulate unit. One product per enabled cycle; 'clear'
// starts a new sum, 'acc' is the running sum including this cycle's product.
// Optional build macro: MM2X2_SEQUENCER_SIGNED_EN (two's complement operands).
module mm2x2_mac
    import mm2x2_seq_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        a,
    input  logic [DATA_W-1:0]        b,
    input  logic                     clear,
    input  logic                     en,
    output logic [res_w(DATA_W)-1:0] acc
);

    localparam int RES_W = res_w(DATA_W);

    logic [RES_W-1:0] w_ax;
    logic [RES_W-1:0] w_bx;
    logic [RES_W-1:0] w_prod;
    logic [RES_W-1:0] w_sum;
    logic [RES_W-1:0] r_acc;

    // Widen operands to RES_W; modulo-2^RES_W arithmetic then gives the
    // right bit pattern for both signed and unsigned interpretations.
`ifdef MM2X2_SEQUENCER_SIGNED_EN
    assign w_ax = {{(RES_W-DATA_W){a[DATA_W-1]}}, a};
    assign w_bx = {{(RES_W-DATA_W){b[DATA_W-1]}}, b};
`else
    assign w_ax = {{(RES_W-DATA_W){1'b0}}, a};
    assign w_bx = {{(RES_W-DATA_W){1'b0}}, b};
`endif

    assign w_prod = w_ax * w_bx;
    assign w_sum  = (clear ? '0 : r_acc) + w_prod;
    assign acc    = w_sum;

    // Accumulator register; holds when not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_acc <= '0;
        else if (en)
            r_acc <= w_sum;
    end

endmodule

// File: rtl/mm2x2_sequencer.sv
// 2x2 matrix-multiply sequencer: loads A then B (row-major) over a byte
// stream, runs eight MAC cycles on one shared multiplier, and streams
// C00..C11 out with their indices.
// Optional build macro: MM2X2_SEQUENCER_SIGNED_EN (handled in mm2x2_mac).
module mm2x2_sequencer
    import mm2x2_seq_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mm2x2_sequencer_if.slave   sq,
    input  logic               abort,
    output logic               busy
);

    localparam int RES_W = res_w(DATA_W);

    state_t r_state;
    state_t w_state_nxt;

    logic [2:0] r_ld_idx;
    logic [2:0] r_pcnt;
    logic [1:0] r_ridx;

    logic [N_OPERANDS-1:0][DATA_W-1:0] r_ops;
    logic [N_RESULTS-1:0][RES_W-1:0]   r_res;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_i;
    logic             w_j;
    logic             w_k;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [RES_W-1:0] w_acc;
    logic             w_mac_en;

    // Product p decodes to C[i][j] += A[i][k]*B[k][j] with i=p[2], j=p[1], k=p[0].
    assign w_i = r_pcnt[2];
    assign w_j = r_pcnt[1];
    assign w_k = r_pcnt[0];

    // A occupies operand slots 0..3, B slots 4..7, both row-major.
    assign w_a = r_ops[{1'b0, w_i, w_k}];
    assign w_b = r_ops[{1'b1, w_k, w_j}];

    assign w_in_xfer  = sq.in_valid  && (r_state == LOAD);
    assign w_out_xfer = sq.out_ready && (r_state == DRAIN);
    assign w_mac_en   = (r_state == COMPUTE) && !abort;

    mm2x2_mac #(
        .DATA_W (DATA_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (w_a),
        .b     (w_b),
        .clear (!w_k),
        .en    (w_mac_en),
        .acc   (w_acc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= LOAD;
        else
            r_state <= w_state_nxt;
    end

    // Next state and handshake outputs; abort overrides any transfer.
    always_comb begin
        w_state_nxt  = r_state;
        sq.in_ready  = 1'b0;
        sq.out_valid = 1'b0;
        sq.out_idx   = r_ridx;
        sq.out_data  = '0;
        busy         = 1'b0;
        case (r_state)
            LOAD: begin
                sq.in_ready = 1'b1;
                if (w_in_xfer && (r_ld_idx == 3'(N_OPERANDS - 1)))
                    w_state_nxt = COMPUTE;
            end
            COMPUTE: begin
                busy = 1'b1;
                if (r_pcnt == 3'(N_PRODUCTS - 1))
                    w_state_nxt = DRAIN;
            end
            DRAIN: begin
                busy         = 1'b1;
                sq.out_valid = 1'b1;
                sq.out_data  = r_res[r_ridx];
                if (w_out_xfer && (r_ridx == 2'(N_RESULTS - 1)))
                    w_state_nxt = LOAD;
            end
            default: w_state_nxt = LOAD;
        endcase
        if (abort)
            w_state_nxt = LOAD;
    end

    // Load, product and result counters; each wraps to 0 at the end of its
    // phase, and abort zeroes them all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_idx <= '0;
            r_pcnt   <= '0;
            r_ridx   <= '0;
        end else if (abort) begin
            r_ld_idx <= '0;
            r_pcnt   <= '0;
            r_ridx   <= '0;
        end else begin
            if (w_in_xfer)
                r_ld_idx <= r_ld_idx + 3'd1;
            if (r_state == COMPUTE)
                r_pcnt <= r_pcnt + 3'd1;
            if (w_out_xfer)
                r_ridx <= r_ridx + 2'd1;
        end
    end

    // Operand storage; an aborted transfer is not stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ops <= '0;
        else if (w_in_xfer && !abort)
            r_ops[r_ld_idx] <= sq.in_data;
    end

    // Result storage: C[i][j] is complete on the k=1 product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_res <= '0;
        else if (w_mac_en && w_k)
            r_res[{w_i, w_j}] <= w_acc;
    end

endmodule

// File: tb/tb_mm2x2_sequencer.sv
// Directed bench for mm2x2_sequencer with a matrix-product reference model
// and a per-cycle output checker.
module tb_mm2x2_sequencer;

    typedef logic [3:0] mat_t [8];
    typedef struct {
        logic [1:0] idx;
        logic [8:0] data;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    logic busy;

    mm2x2_sequencer_if #(.DATA_W(4)) ifc ();

    mm2x2_sequencer #(.DATA_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sq    (ifc),
        .abort (abort),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   errors = 0;
    int   checks = 0;
    res_t exp_q[$];
    logic [8:0] got [4];
    int   t_last = 0;
    bit   lat_pending = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int elem(input logic [3:0] v);
`ifdef MM2X2_SEQUENCER_SIGNED_EN
        return int'($signed(v));
`else
        return int'(v);
`endif
    endfunction

    // Reference: plain matrix product, results queued in index order.
    task automatic push_model(input mat_t m);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                int s;
                res_t r;
                s = 0;
                for (int k = 0; k < 2; k++)
                    s += elem(m[i*2+k]) * elem(m[4+k*2+j]);
                r.idx  = 2'(i*2+j);
                r.data = 9'(s);
                exp_q.push_back(r);
            end
    endtask

    // Output checker: order, values, stability under backpressure, latency.
    initial begin
        bit         prev_v;
        bit         prev_r;
        logic [1:0] prev_idx;
        logic [8:0] prev_data;
        res_t       r;
        prev_v = 0; prev_r = 0; prev_idx = '0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 0;
            end else begin
                if (ifc.out_valid) begin
                    if (lat_pending) begin
                        chk("latency", cyc, t_last + 9);
                        lat_pending = 0;
                    end
                    if (prev_v && !prev_r) begin
                        chk("hold_idx", int'(ifc.out_idx), int'(prev_idx));
                        chk("hold_data", int'(ifc.out_data), int'(prev_data));
                    end
                    if (ifc.out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_out_valid", 1, 0);
                        end else begin
                            r = exp_q.pop_front();
                            chk("out_idx", int'(ifc.out_idx), int'(r.idx));
                            chk("out_data", int'(ifc.out_data), int'(r.data));
                            got[ifc.out_idx] = ifc.out_data;
                        end
                    end
                end
                prev_v    = ifc.out_valid;
                prev_r    = ifc.out_ready;
                prev_idx  = ifc.out_idx;
                prev_data = ifc.out_data;
            end
        end
    end

    // Feed eight operands; optional random gaps; optional abort on the 8th.
    task automatic load(input mat_t m, input bit gaps, input bit push, input bit abort_last);
        for (int e = 0; e < 8; e++) begin
            int n;
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int x = 0; x < g; x++) begin
                    ifc.in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            ifc.in_valid = 1'b1;
            ifc.in_data  = m[e];
            if (abort_last && e == 7) abort = 1'b1;
            n = 0;
            while (!ifc.in_ready && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 50) chk("in_ready_timeout", 0, 1);
            @(posedge clk); #1;
            ifc.in_valid = 1'b0;
            abort = 1'b0;
        end
        t_last = cyc - 1;
        if (push) begin
            push_model(m);
            lat_pending = 1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 0, 1);
        @(posedge clk); #1;
        chk("post_drain_in_ready", int'(ifc.in_ready), 1);
        chk("post_drain_out_valid", int'(ifc.out_valid), 0);
        chk("post_drain_busy", int'(busy), 0);
    endtask

    task automatic wait_out(input int idx);
        int n;
        n = 0;
        while (!(ifc.out_valid && (idx < 0 || int'(ifc.out_idx) == idx)) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("out_valid_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        mat_t m_basic, m_tmp;
        m_basic = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", int'(ifc.out_valid), 0);
        chk("rst_out_data", int'(ifc.out_data), 0);
        chk("rst_out_idx", int'(ifc.out_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(ifc.in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic multiply
        load(m_basic, 0, 1, 0);
        chk("compute_busy", int'(busy), 1);
        chk("compute_in_ready", int'(ifc.in_ready), 0);
        wait_drain();
        chk("basic_c00", int'(got[0]), 19);
        chk("basic_c01", int'(got[1]), 22);
        chk("basic_c10", int'(got[2]), 43);
        chk("basic_c11", int'(got[3]), 50);

`ifdef MM2X2_SEQUENCER_SIGNED_EN
        // Signed: all -8
        m_tmp = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8};
        load(m_tmp, 0, 1, 0);
        wait_drain();
        for (int i = 0; i < 4; i++) chk("signed_min", int'($signed(got[i])), 128);
        // Signed mixed
        m_tmp = '{4'hF, 4'd2, 4'd3, 4'hC, 4'd5, 4'hA, 4'd7, 4'd8};
        load(m_tmp, 1, 1, 0);
        wait_drain();
        chk("signed_c00", int'($signed(got[0])), 9);
        chk("signed_c01", int'($signed(got[1])), 22);
        chk("signed_c10", int'($signed(got[2])), -13);
        chk("signed_c11", int'($signed(got[3])), -50);
`else
        // Unsigned max
        m_tmp = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        load(m_tmp, 0, 1, 0);
        wait_drain();
        for (int i = 0; i < 4; i++) chk("unsigned_max", int'(got[i]), 450);
`endif

        // Zero matrix
        m_tmp = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        load(m_tmp, 0, 1, 0);
        wait_drain();
        for (int i = 0; i < 4; i++) chk("zero", int'(got[i]), 0);

        // Backpressure on idx 1, with input gaps
        ifc.out_ready = 1'b0;
        load(m_basic, 1, 1, 0);
        wait_out(-1);
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("bp_idx", int'(ifc.out_idx), 1);
            chk("bp_data", int'(ifc.out_data), 22);
        end
        ifc.out_ready = 1'b1;
        wait_drain();

        // Abort in COMPUTE cycle 4
        load(m_basic, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_in_ready", int'(ifc.in_ready), 1);
        chk("abort_busy", int'(busy), 0);
        repeat (12) @(posedge clk);
        #1;
        m_tmp = '{4'd1, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        load(m_tmp, 0, 1, 0);
        wait_drain();
        chk("ident_c00", int'(got[0]), 2);
        chk("ident_c01", int'(got[1]), 3);
        chk("ident_c10", int'(got[2]), 4);
        chk("ident_c11", int'(got[3]), 5);

        // Abort coincident with the 8th operand
        load(m_tmp, 0, 0, 1);
        chk("abort8_in_ready", int'(ifc.in_ready), 1);
        chk("abort8_busy", int'(busy), 0);
        repeat (12) @(posedge clk);
        #1;
        load(m_basic, 1, 1, 0);
        wait_drain();

        // Reset mid-DRAIN, after idx 1 transfers
        load(m_basic, 0, 1, 0);
        wait_out(1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(ifc.out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_in_ready", int'(ifc.in_ready), 1);
        exp_q.delete();
        lat_pending = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load(m_basic, 0, 1, 0);
        wait_drain();
        chk("after_rst_c11", int'(got[3]), 50);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
